// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment scan controller:
//   - scan_state_t : scan FSM states (GAP = dead time, SHOW = digit lit)
//   - SEG_OFF      : all segments dark (active-low)
//   - AN_OFF       : all anodes off (active-low)
//   - HEX_SEG      : hex nibble -> active-low segments, bit order {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
package seg_pkg;

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Index = nibble value; entry = active-low {g,f,e,d,c,b,a}.
  localparam logic [6:0] HEX_SEG [0:15] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// ---------------------------------------------------------------------------
// hex7seg
// Combinational hex-to-seven-segment decoder (active-low outputs).
// Ports:
//   nib  input  [3:0]  hex nibble
//   seg  output [6:0]  active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Each digit slot is GAP_CNT cycles of all-off dead time followed by DIV_CNT
// cycles with the digit lit. Digits are scanned 7 down to 0, then wrap.
// Ports:
//   clk        input        system clock, rising edge
//   rstn       input        asynchronous active-low reset
//   en_mask    input  [7:0] per-digit enable, bit i = digit i
//   lz_blank   input        1 = blank leading zeros
//   s          output [2:0] digit select to the external nibble mux
//   y          input  [3:0] nibble returned by the mux for digit s
//   an         output [7:0] active-low anodes (at most one bit low)
//   seg        output [6:0] active-low segments {g,f,e,d,c,b,a}
//   frame_done output       one-cycle pulse after digit 0's slot ends
// ---------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIV_CNT = 100000,
  parameter int GAP_CNT = 1000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] en_mask,
  input  logic       lz_blank,
  output logic [2:0] s,
  input  logic [3:0] y,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam int MAX_CNT = (DIV_CNT > GAP_CNT) ? DIV_CNT : GAP_CNT;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CNT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CNT - 1);

  scan_state_t   state_reg;
  logic [CW-1:0] cnt_reg;
  logic          seen_nz_reg;   // a non-zero enabled digit has been latched this frame

  logic [6:0]    dec_seg;
  logic [7:0]    an_lit;
  logic          nz;
  logic          show;

  hex7seg u_hex7seg (
    .nib (y),
    .seg (dec_seg)
  );

  // One-hot-low anode pattern for the currently selected digit.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_an
      assign an_lit[gi] = (s != 3'(gi));
    end
  endgenerate

  assign nz   = (y != 4'd0);
  // Digit 0 is never blanked so a value of zero still shows a single "0".
  assign show = en_mask[s] && (!lz_blank || nz || seen_nz_reg || (s == 3'd0));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= GAP;
      cnt_reg     <= '0;
      seen_nz_reg <= 1'b0;
      s           <= 3'd7;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_reg)
        GAP: begin
          if (cnt_reg == GAP_LAST) begin
            // Latch point: y has been stable for the whole gap.
            cnt_reg   <= '0;
            state_reg <= SHOW;
            if (show) begin
              an  <= an_lit;
              seg <= dec_seg;
            end else begin
              an  <= AN_OFF;
              seg <= SEG_OFF;
            end
            if (en_mask[s] && nz) begin
              seen_nz_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_reg == DIV_LAST) begin
            cnt_reg   <= '0;
            state_reg <= GAP;
            an        <= AN_OFF;
            seg       <= SEG_OFF;
            s         <= s - 3'd1;  // 0 wraps to 7
            if (s == 3'd0) begin
              frame_done  <= 1'b1;
              seen_nz_reg <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= GAP;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule
